// File: rtl/chk_loop_sweep.sv
// Power-up delay, then a PRBS7 loopback check of each of N_CH channels in turn.
// Define CHK_ERR_CNT_EN to add the per-channel 8-bit mismatch count output err_cnt.
module chk_loop_sweep #(
    parameter int N_CH     = 8,
    parameter int DELAY    = 5000000,
    parameter int PAT_LEN  = 16,
    parameter int LOOP_LAT = 2,
    parameter int BIT_DIV  = 4
) (
    input  logic                    clk_100Mz,
    input  logic                    reset,
    input  logic                    tick_1Mz,
    input  logic                    start,
    input  logic                    mode_cont,
    input  logic [N_CH-1:0]         lb_in,
    output logic [N_CH-1:0]         lb_out,
    output logic [$clog2(N_CH)-1:0] ch_sel,
    output logic                    busy,
    output logic [N_CH-1:0]         ready_channel,
    output logic [N_CH-1:0]         fail_channel,
    output logic                    status_valid,
    output logic [$clog2(N_CH):0]   pass_cnt
`ifdef CHK_ERR_CNT_EN
    ,
    output logic [N_CH*8-1:0]       err_cnt
`endif
);
    localparam int CW      = $clog2(N_CH);
    localparam int DW      = $clog2(DELAY) + 1;
    localparam int BW      = $clog2(BIT_DIV);
    localparam int PERIODS = PAT_LEN + LOOP_LAT;
    localparam int PW      = $clog2(PERIODS) + 1;
    localparam int EW      = $clog2(PAT_LEN) + 1;

    localparam logic [2:0] S_DELAY = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state;
    logic [DW-1:0]       dcnt;
    logic [BW-1:0]       bcnt;
    logic [PW-1:0]       pcnt;
    logic [6:0]          prbs;
    logic [LOOP_LAT-1:0] hist;
    logic [EW-1:0]       err;
    logic [N_CH-1:0]     sync1, sync2;
    logic [N_CH-1:0]     ready_nxt;
    logic                bit_end, run_end, mismatch;

    function automatic logic [CW:0] popcount(input logic [N_CH-1:0] v);
        logic [CW:0] n;
        n = '0;
        for (int i = 0; i < N_CH; i++) n += (CW+1)'(v[i]);
        return n;
    endfunction

    assign bit_end  = (bcnt == BW'(BIT_DIV-1));
    assign run_end  = bit_end && (pcnt == PW'(PERIODS-1));
    // hist[LOOP_LAT-1] is the bit transmitted LOOP_LAT periods before the current one
    assign mismatch = (pcnt >= PW'(LOOP_LAT)) && (sync2[ch_sel] != hist[LOOP_LAT-1]);

    assign busy         = (state == S_RUN) || (state == S_NEXT) || (state == S_DONE);
    assign status_valid = (state == S_DONE);

    always_comb begin
        lb_out = '0;
        if (state == S_RUN) lb_out[ch_sel] = prbs[6];
    end

    always_comb begin
        ready_nxt         = ready_channel;
        ready_nxt[ch_sel] = (err == '0);
    end

    always_ff @(posedge clk_100Mz) begin
        if (reset) begin
            state         <= S_DELAY;
            dcnt          <= '0;
            ch_sel        <= '0;
            bcnt          <= '0;
            pcnt          <= '0;
            prbs          <= 7'h7F;
            hist          <= '0;
            err           <= '0;
            sync1         <= '0;
            sync2         <= '0;
            ready_channel <= '0;
            fail_channel  <= '0;
            pass_cnt      <= '0;
        end else begin
            sync1 <= lb_in;
            sync2 <= sync1;
            case (state)
                S_DELAY: begin
                    if (start) begin
                        state  <= S_RUN;
                        ch_sel <= '0;
                    end else if (tick_1Mz) begin
                        if (dcnt == DW'(DELAY-1)) begin
                            state  <= S_RUN;
                            ch_sel <= '0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        ch_sel <= '0;
                    end
                end
                S_RUN: begin
                    bcnt <= bit_end ? '0 : bcnt + 1'b1;
                    if (bit_end) begin
                        prbs <= {prbs[5:0], prbs[6] ^ prbs[5]};
                        hist <= LOOP_LAT'({hist, prbs[6]});
                        pcnt <= pcnt + 1'b1;
                        if (mismatch && err != '1) err <= err + 1'b1;
                    end
                    // RUN is only left here or by reset, so reseeding on exit
                    // guarantees a fresh pattern on every RUN entry
                    if (run_end) begin
                        state <= S_NEXT;
                        prbs  <= 7'h7F;
                        pcnt  <= '0;
                    end
                end
                S_NEXT: begin
                    ready_channel        <= ready_nxt;
                    fail_channel[ch_sel] <= (err != '0);
                    err                  <= '0;
                    if (ch_sel == CW'(N_CH-1)) begin
                        state    <= S_DONE;
                        pass_cnt <= popcount(ready_nxt);
                    end else begin
                        ch_sel <= ch_sel + 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (mode_cont) begin
                        state  <= S_RUN;
                        ch_sel <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_DELAY;
            endcase
        end
    end

`ifdef CHK_ERR_CNT_EN
    logic [EW+7:0] err_ext;
    assign err_ext = (EW+8)'(err);

    always_ff @(posedge clk_100Mz) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (state == S_NEXT) begin
            err_cnt[ch_sel*8 +: 8] <= (err_ext > (EW+8)'(255)) ? 8'hFF : err_ext[7:0];
        end
    end
`endif
endmodule

// File: tb/tb_chk_loop_sweep.sv
// Directed bench for chk_loop_sweep: 8 channels, DELAY=4, external loop of 2 bit periods.
`timescale 1ns/1ps
module tb_chk_loop_sweep;
    logic       clk_100Mz = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1Mz = 1'b0;
    logic       start = 1'b0;
    logic       mode_cont = 1'b0;
    logic [7:0] lb_in = '0;
    logic [7:0] lb_out;
    logic [2:0] ch_sel;
    logic       busy;
    logic [7:0] ready_channel;
    logic [7:0] fail_channel;
    logic       status_valid;
    logic [3:0] pass_cnt;
`ifdef CHK_ERR_CNT_EN
    logic [63:0] err_cnt;
`endif

    int n_checks = 0;
    int n_pass = 0;

    chk_loop_sweep #(.N_CH(8), .DELAY(4), .PAT_LEN(16), .LOOP_LAT(2), .BIT_DIV(4)) dut (
        .clk_100Mz(clk_100Mz), .reset(reset), .tick_1Mz(tick_1Mz), .start(start),
        .mode_cont(mode_cont), .lb_in(lb_in), .lb_out(lb_out), .ch_sel(ch_sel),
        .busy(busy), .ready_channel(ready_channel), .fail_channel(fail_channel),
        .status_valid(status_valid), .pass_cnt(pass_cnt)
`ifdef CHK_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk_100Mz = ~clk_100Mz;

    // 1 MHz strobe: one cycle in every 100
    logic tick_en = 1'b0;
    int   tdiv = 0;
    always @(negedge clk_100Mz) begin
        if (!tick_en) tdiv = 0;
        else tdiv = (tdiv == 99) ? 0 : tdiv + 1;
        tick_1Mz = tick_en && (tdiv == 99);
    end

    // External loop: lb_in is lb_out from 8 cycles (2 bit periods) earlier, with fault injection
    logic [7:0] lbh [0:8];
    logic [7:0] zero_mask = '0;
    logic       inv_en = 1'b0;
    logic       prev_busy = 1'b0;
    logic [2:0] prev_ch = '0;
    int         rcyc = 0;
    initial for (int k = 0; k <= 8; k++) lbh[k] = '0;
    always @(negedge clk_100Mz) begin
        logic [7:0] v;
        for (int k = 8; k > 0; k--) lbh[k] = lbh[k-1];
        lbh[0] = lb_out;
        if (busy && (!prev_busy || ch_sel != prev_ch)) rcyc = 0;
        else rcyc++;
        prev_busy = busy;
        prev_ch = ch_sel;
        v = lbh[8] & ~zero_mask;
        // returned copy of the bit sent in period 10 of channel 5 (compared bit 10)
        if (inv_en && ch_sel == 3'd5 && rcyc >= 48 && rcyc <= 51) v[5] = ~v[5];
        lb_in = v;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(posedge clk_100Mz); #1;
        reset = 1'b1; start = 1'b0; mode_cont = 1'b0; tick_en = 1'b0;
        zero_mask = '0; inv_en = 1'b0;
        @(posedge clk_100Mz); #1;
        reset = 1'b0;
    endtask

    // returns with the DUT in its first RUN cycle of channel 0
    task automatic pulse_start;
        @(posedge clk_100Mz); #1;
        start = 1'b1;
        @(posedge clk_100Mz); #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(output bit found);
        found = 0;
        pulse_start();
        for (int c = 0; c < 700 && !found; c++) begin
            @(posedge clk_100Mz); #1;
            if (status_valid) found = 1;
        end
        @(posedge clk_100Mz); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk_100Mz);
        #1;
        n_checks++; if (lb_out !== 8'h00) $display("FAIL rst_lb_out: got %h expected 00", lb_out); else n_pass++;
        n_checks++; if (ch_sel !== 3'd0) $display("FAIL rst_ch_sel: got %0d expected 0", ch_sel); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ready_channel !== 8'h00) $display("FAIL rst_ready: got %h expected 00", ready_channel); else n_pass++;
        n_checks++; if (fail_channel !== 8'h00) $display("FAIL rst_fail: got %h expected 00", fail_channel); else n_pass++;
        n_checks++; if (status_valid !== 1'b0) $display("FAIL rst_status_valid: got %b expected 0", status_valid); else n_pass++;
        n_checks++; if (pass_cnt !== 4'd0) $display("FAIL rst_pass_cnt: got %0d expected 0", pass_cnt); else n_pass++;
`ifdef CHK_ERR_CNT_EN
        n_checks++; if (err_cnt !== 64'h0) $display("FAIL rst_err_cnt: got %h expected 0", err_cnt); else n_pass++;
`endif
        reset = 1'b0;
        repeat (20) @(posedge clk_100Mz);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL delay_hold_no_tick: busy got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_delay_sweep;
        int nt, sv_at, sv_cnt;
        logic busy_585;
        logic [3:0] pc_at_sv;
        do_reset();
        tick_en = 1'b1;
        nt = 0;
        for (int i = 0; i < 1000 && nt < 4; i++) begin
            @(posedge clk_100Mz);
            if (tick_1Mz) begin
                nt++;
                #1;
                if (nt == 3) begin
                    n_checks++; if (busy !== 1'b0) $display("FAIL busy_after_tick3: got %b expected 0", busy); else n_pass++;
                end
                if (nt == 4) begin
                    n_checks++; if (busy !== 1'b1) $display("FAIL busy_after_tick4: got %b expected 1", busy); else n_pass++;
                    n_checks++; if (ch_sel !== 3'd0) $display("FAIL ch_sel_first_run: got %0d expected 0", ch_sel); else n_pass++;
                end
            end
        end
        n_checks++; if (nt != 4) $display("FAIL delay_ticks: got %0d ticks expected 4", nt); else n_pass++;
        tick_en = 1'b0;
        sv_at = -1; sv_cnt = 0; busy_585 = 1'bx; pc_at_sv = 'x;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk_100Mz); #1;
            if (status_valid) begin
                sv_cnt++;
                if (sv_at < 0) sv_at = c;
                pc_at_sv = pass_cnt;
            end
            if (c == 585) busy_585 = busy;
        end
        n_checks++; if (sv_at != 584) $display("FAIL sweep_done_cycle: got %0d expected 584", sv_at); else n_pass++;
        n_checks++; if (sv_cnt != 1) $display("FAIL status_valid_width: got %0d cycles expected 1", sv_cnt); else n_pass++;
        n_checks++; if (busy_585 !== 1'b0) $display("FAIL busy_after_done: got %b expected 0", busy_585); else n_pass++;
        n_checks++; if (ready_channel !== 8'hFF) $display("FAIL sweep_ready: got %h expected FF", ready_channel); else n_pass++;
        n_checks++; if (fail_channel !== 8'h00) $display("FAIL sweep_fail: got %h expected 00", fail_channel); else n_pass++;
        n_checks++; if (pc_at_sv !== 4'd8) $display("FAIL pass_cnt_at_done: got %0d expected 8", pc_at_sv); else n_pass++;
        n_checks++; if (pass_cnt !== 4'd8) $display("FAIL pass_cnt_held: got %0d expected 8", pass_cnt); else n_pass++;
    endtask

    task automatic test_stuck_ch3;
        bit found;
        do_reset();
        zero_mask = 8'h08;
        run_sweep(found);
        n_checks++; if (!found) $display("FAIL stuck_timeout: got no status_valid expected one"); else n_pass++;
        n_checks++; if (ready_channel !== 8'hF7) $display("FAIL stuck_ready: got %h expected F7", ready_channel); else n_pass++;
        n_checks++; if (fail_channel !== 8'h08) $display("FAIL stuck_fail: got %h expected 08", fail_channel); else n_pass++;
        n_checks++; if (pass_cnt !== 4'd7) $display("FAIL stuck_pass_cnt: got %0d expected 7", pass_cnt); else n_pass++;
`ifdef CHK_ERR_CNT_EN
        // 8 ones among the 16 compared PRBS7 bits 1111111000000100
        n_checks++; if (err_cnt !== 64'h0000_0000_0800_0000) $display("FAIL stuck_err_cnt: got %h expected 0000000008000000", err_cnt); else n_pass++;
`endif
    endtask

    task automatic test_single_flip;
        bit found;
        do_reset();
        inv_en = 1'b1;
        run_sweep(found);
        n_checks++; if (!found) $display("FAIL flip_timeout: got no status_valid expected one"); else n_pass++;
        n_checks++; if (fail_channel !== 8'h20) $display("FAIL flip_fail: got %h expected 20", fail_channel); else n_pass++;
        n_checks++; if (ready_channel !== 8'hDF) $display("FAIL flip_ready: got %h expected DF", ready_channel); else n_pass++;
`ifdef CHK_ERR_CNT_EN
        n_checks++; if (err_cnt !== 64'h0000_0100_0000_0000) $display("FAIL flip_err_cnt: got %h expected 0000010000000000", err_cnt); else n_pass++;
`endif
    endtask

    task automatic test_cont;
        bit found;
        int c;
        do_reset();
        mode_cont = 1'b1;
        pulse_start();
        found = 0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(posedge clk_100Mz); #1;
            if (status_valid) found = 1;
        end
        n_checks++; if (!found) $display("FAIL cont_first_timeout: got no status_valid expected one"); else n_pass++;
        for (int g = 0; g < 2; g++) begin
            c = 0; found = 0;
            while (c < 700 && !found) begin
                @(posedge clk_100Mz); #1;
                c++;
                if (status_valid) found = 1;
                if (g == 1 && c == 100) start = 1'b1;
                if (g == 1 && c == 101) start = 1'b0;
                if (g == 1 && c == 200) mode_cont = 1'b0;
            end
            n_checks++; if (c != 585) $display("FAIL cont_period%0d: got %0d expected 585", g, c); else n_pass++;
        end
        n_checks++; if (pass_cnt !== 4'd8) $display("FAIL cont_pass_cnt: got %0d expected 8", pass_cnt); else n_pass++;
        @(posedge clk_100Mz); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL cont_stop_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int i;
        do_reset();
        pulse_start();
        i = 0;
        while (i < 300 && ch_sel != 3'd2) begin
            @(posedge clk_100Mz); #1;
            i++;
        end
        n_checks++; if (i != 146) $display("FAIL ch2_entry_cycle: got %0d expected 146", i); else n_pass++;
        repeat (10) @(posedge clk_100Mz);
        #1;
        n_checks++; if (ready_channel !== 8'h03) $display("FAIL pre_reset_ready: got %h expected 03", ready_channel); else n_pass++;
        reset = 1'b1;
        @(posedge clk_100Mz); #1;
        n_checks++; if (lb_out !== 8'h00) $display("FAIL mid_rst_lb_out: got %h expected 00", lb_out); else n_pass++;
        n_checks++; if (ready_channel !== 8'h00) $display("FAIL mid_rst_ready: got %h expected 00", ready_channel); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ch_sel !== 3'd0) $display("FAIL mid_rst_ch_sel: got %0d expected 0", ch_sel); else n_pass++;
        reset = 1'b0;
        repeat (5) @(posedge clk_100Mz);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_in_delay: busy got %b expected 0", busy); else n_pass++;
        start = 1'b1;
        @(posedge clk_100Mz); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_delay_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (ch_sel !== 3'd0) $display("FAIL abort_delay_ch_sel: got %0d expected 0", ch_sel); else n_pass++;
    endtask

    task automatic test_prbs_out;
        logic [7:0] exp_bits;
        logic       upper_ok;
        exp_bits = 8'b1111_1110;
        upper_ok = 1'b1;
        do_reset();
        pulse_start();
        for (int c = 0; c < 32; c++) begin
            if (c > 0) begin
                @(posedge clk_100Mz); #1;
            end
            if (lb_out[7:1] !== 7'h00) upper_ok = 1'b0;
            if (c % 4 == 1) begin
                n_checks++;
                if (lb_out[0] !== exp_bits[7 - c/4])
                    $display("FAIL prbs_bit%0d: got %b expected %b", c/4, lb_out[0], exp_bits[7 - c/4]);
                else n_pass++;
            end
        end
        n_checks++; if (upper_ok !== 1'b1) $display("FAIL prbs_other_lines: got nonzero expected 0"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_delay_sweep();
        test_stuck_ch3();
        test_single_flip();
        test_cont();
        test_reset_mid();
        test_prbs_out();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
